// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared screen geometry, pixel widths and plot-port state encoding
package plot_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOR_W  = 3;
  localparam int COORD_W  = 8;

  typedef enum logic {
    ARB,
    CLEAR
  } plot_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr, one-hot grant plus index
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         idx
);
  logic found;

  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int unsigned cand;
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = 2'(cand);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = enable && found && (idx == 2'(j));
    end
  end
endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - shares the VGA adapter pixel-write port between clients and a clear engine
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int SCREEN_W = plot_pkg::SCREEN_W,
  parameter int SCREEN_H = plot_pkg::SCREEN_H
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear_start,
  input  logic [plot_pkg::COLOR_W-1:0]          clear_color,
  output logic                                  clear_busy,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [plot_pkg::COORD_W*NUM_REQ-1:0]  req_x,
  input  logic [plot_pkg::COORD_W*NUM_REQ-1:0]  req_y,
  input  logic [plot_pkg::COLOR_W*NUM_REQ-1:0]  req_color,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [plot_pkg::COORD_W-1:0]          x,
  output logic [plot_pkg::COORD_W-1:0]          y,
  output logic [plot_pkg::COLOR_W-1:0]          color,
  output logic                                  plot,
  output logic [1:0]                            grant_id
);
  import plot_pkg::*;

  plot_state_t        state, state_next;
  logic [COORD_W-1:0] cx, cy;
  logic [COLOR_W-1:0] clr_col;
  logic [1:0]         rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         sel_idx;
  logic               arb_enable, accept, in_range, clear_last;
  logic [COORD_W-1:0] sel_x, sel_y;
  logic [COLOR_W-1:0] sel_color;

  // clear_start blocks acceptance in its own cycle so the clear owns the very next slot
  assign arb_enable = !reset && (state == ARB) && !clear_start;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .enable (arb_enable),
    .grant  (grant),
    .idx    (sel_idx)
  );

  assign req_ready  = grant;
  assign accept     = |grant;
  assign clear_busy = (state == CLEAR);
  assign clear_last = (cx == COORD_W'(SCREEN_W - 1)) && (cy == COORD_W'(SCREEN_H - 1));

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x     = req_x[COORD_W*i +: COORD_W];
        sel_y     = req_y[COORD_W*i +: COORD_W];
        sel_color = req_color[COLOR_W*i +: COLOR_W];
      end
    end
  end

  assign in_range = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (clear_start) state_next = CLEAR;
      CLEAR:   if (clear_last)  state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  // cx/cy track the pixel currently on the output registers during a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      color    <= '0;
      plot     <= 1'b0;
      grant_id <= 2'd0;
      rr_ptr   <= 2'd0;
      cx       <= '0;
      cy       <= '0;
      clr_col  <= '0;
    end else begin
      plot <= 1'b0;
      if (state == ARB) begin
        if (clear_start) begin
          clr_col  <= clear_color;
          cx       <= '0;
          cy       <= '0;
          x        <= '0;
          y        <= '0;
          color    <= clear_color;
          plot     <= 1'b1;
          grant_id <= 2'd3;
        end else if (accept) begin
          x        <= sel_x;
          y        <= sel_y;
          color    <= sel_color;
          plot     <= in_range;
          grant_id <= sel_idx;
          rr_ptr   <= (sel_idx == 2'(NUM_REQ - 1)) ? 2'd0 : sel_idx + 2'd1;
        end
      end else if (!clear_last) begin
        if (cx == COORD_W'(SCREEN_W - 1)) begin
          cx <= '0;
          cy <= cy + 1'b1;
          x  <= '0;
          y  <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
          x  <= cx + 1'b1;
          y  <= cy;
        end
        color    <= clr_col;
        plot     <= 1'b1;
        grant_id <= 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        clear_start;
  logic [2:0]  clear_color;
  logic        clear_busy;
  logic [1:0]  req_valid;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [5:0]  req_color;
  logic [1:0]  req_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [2:0]  color;
  logic        plot;
  logic [1:0]  grant_id;

  int errors = 0;
  int checks = 0;

  vga_plot_arbiter #(.NUM_REQ(2), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .req_ready   (req_ready),
    .x           (x),
    .y           (y),
    .color       (color),
    .plot        (plot),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled at the negedge, half a period from the active edge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    clear_start = 1'b0;
    clear_color = 3'd0;
    req_valid   = 2'b11;
    req_x       = {8'd30, 8'd10};
    req_y       = {8'd40, 8'd20};
    req_color   = {3'd2, 3'd1};
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL reset_ready cycle %0d: got %b want 00", i, req_ready);
      end
      cyc();
      checks++;
      if ({x, y, color, plot, grant_id, clear_busy} !== 23'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: x=%0d y=%0d c=%0d plot=%b gid=%0d busy=%b want all 0",
                 i, x, y, color, plot, grant_id, clear_busy);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL first_grant_ready: got %b want 01", req_ready);
    end
    cyc();
    checks++;
    if ({plot, x, y, color, grant_id} !== {1'b1, 8'd10, 8'd20, 3'd1, 2'd0}) begin
      errors++;
      $display("FAIL first_grant_plot: plot=%b x=%0d y=%0d c=%0d gid=%0d want 1 10 20 1 0",
               plot, x, y, color, grant_id);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ex, ey;
    logic [2:0] ec;
    int         id;
    for (int k = 0; k < 6; k++) begin
      id = (k % 2 == 0) ? 1 : 0;
      ex = (id == 1) ? 8'd30 : 8'd10;
      ey = (id == 1) ? 8'd40 : 8'd20;
      ec = (id == 1) ? 3'd2 : 3'd1;
      #1;
      checks++;
      if (req_ready !== ((id == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_ready step %0d: got %b want client %0d", k, req_ready, id);
      end
      cyc();
      checks++;
      if ({plot, x, y, color, grant_id} !== {1'b1, ex, ey, ec, 2'(id)}) begin
        errors++;
        $display("FAIL rr_plot step %0d: plot=%b x=%0d y=%0d c=%0d gid=%0d want 1 %0d %0d %0d %0d",
                 k, plot, x, y, color, grant_id, ex, ey, ec, id);
      end
    end
    req_valid = 2'b00;
    cyc();
    checks++;
    if ({plot, x, y, color} !== {1'b0, 8'd10, 8'd20, 3'd1}) begin
      errors++;
      $display("FAIL idle_hold: plot=%b x=%0d y=%0d c=%0d want 0 10 20 1", plot, x, y, color);
    end
  endtask

  task automatic test_out_of_range();
    req_valid = 2'b10;
    req_x     = {8'd160, 8'd10};
    req_y     = {8'd5, 8'd20};
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL oor_x_ready: got %b want 10", req_ready);
    end
    cyc();
    checks++;
    if (plot !== 1'b0) begin
      errors++;
      $display("FAIL oor_x_plot: got %b want 0", plot);
    end
    req_x = {8'd5, 8'd10};
    req_y = {8'd120, 8'd20};
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL oor_y_ready: got %b want 10", req_ready);
    end
    cyc();
    checks++;
    if (plot !== 1'b0) begin
      errors++;
      $display("FAIL oor_y_plot: got %b want 0", plot);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL oor_ptr_advance: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_clear();
    logic [7:0] ex, ey;
    req_valid   = 2'b01;
    clear_start = 1'b1;
    clear_color = 3'b101;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL clear_start_blocks_client: got %b want 00", req_ready);
    end
    cyc();
    clear_start = 1'b0;
    for (int i = 0; i < 19200; i++) begin
      ex = 8'(i % 160);
      ey = 8'(i / 160);
      #1;
      checks++;
      if ({plot, x, y, color, clear_busy, req_ready} !== {1'b1, ex, ey, 3'd5, 1'b1, 2'b00}) begin
        errors++;
        $display("FAIL clear_pixel %0d: plot=%b x=%0d y=%0d c=%0d busy=%b ready=%b want 1 %0d %0d 5 1 00",
                 i, plot, x, y, color, clear_busy, req_ready, ex, ey);
      end
      if (i == 100) begin
        clear_start = 1'b1;
        clear_color = 3'b010;
      end else begin
        clear_start = 1'b0;
      end
      cyc();
    end
    #1;
    checks++;
    if ({clear_busy, plot, req_ready} !== {1'b0, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL clear_end: busy=%b plot=%b ready=%b want 0 0 01", clear_busy, plot, req_ready);
    end
    cyc();
    checks++;
    if ({plot, x, y, color, grant_id} !== {1'b1, 8'd10, 8'd20, 3'd1, 2'd0}) begin
      errors++;
      $display("FAIL post_clear_plot: plot=%b x=%0d y=%0d c=%0d gid=%0d want 1 10 20 1 0",
               plot, x, y, color, grant_id);
    end
    req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_abort();
    clear_start = 1'b1;
    clear_color = 3'b011;
    cyc();
    clear_start = 1'b0;
    repeat (5000) cyc();
    checks++;
    if ({plot, x, y, color, clear_busy} !== {1'b1, 8'd40, 8'd31, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL abort_pixel5000: plot=%b x=%0d y=%0d c=%0d busy=%b want 1 40 31 3 1",
               plot, x, y, color, clear_busy);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if ({x, y, color, plot, grant_id, clear_busy} !== 23'd0) begin
      errors++;
      $display("FAIL abort_reset_outputs: x=%0d y=%0d c=%0d plot=%b gid=%0d busy=%b want all 0",
               x, y, color, plot, grant_id, clear_busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({plot, clear_busy} !== 2'b00) begin
        errors++;
        $display("FAIL abort_no_resume cycle %0d: plot=%b busy=%b want 0 0", i, plot, clear_busy);
      end
    end
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL abort_back_in_arb: ready=%b want 10", req_ready);
    end
    req_valid = 2'b00;
    cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_out_of_range();
    test_clear();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single pixel-write port of the 160x120, 3-bit-colour VGA adapter between NUM_REQ drawing clients and a built-in full-screen clear engine. It sits between the drawing datapaths and the adapter's x/y/colour/plot inputs and emits at most one registered plot per cycle. Clients are served round-robin. A clear request pre-empts all clients until the full frame has been written.

## Interface
Parameters:
- NUM_REQ, 2: number of pixel clients (1..4)
- SCREEN_W, 160: visible columns
- SCREEN_H, 120: visible rows

Ports:
- clk  in  1: system clock (50 MHz)
- reset  in  1: synchronous, active-high
- clear_start  in  1: one-cycle pulse; start a full-screen fill
- clear_color  in  3: fill colour, sampled with clear_start
- clear_busy  out  1: high while the clear engine owns the port
- req_valid  in  NUM_REQ: client i has a pixel pending
- req_x  in  8*NUM_REQ: client i x at bits [8i+7:8i]
- req_y  in  8*NUM_REQ: client i y at bits [8i+7:8i]
- req_color  in  3*NUM_REQ: client i colour at bits [3i+2:3i]
- req_ready  out  NUM_REQ: one-hot or zero; pixel accepted when valid & ready
- x  out  8: adapter column
- y  out  8: adapter row
- color  out  3: adapter colour
- plot  out  1: write strobe to the adapter
- grant_id  out  2: source of the current plot (client index; 3 when clear is the source and NUM_REQ<4, otherwise don't-care during a clear)

## Operation
- There are two states, ARB and CLEAR. Reset enters ARB.
- In ARB:
  - Select the first asserted req_valid, searching from rr_ptr upward with wrap.
  - Assert req_ready for the selected client only, and only if clear_start=0.
  - On acceptance, rr_ptr <= selected+1, wrapping modulo NUM_REQ.
- clear_start in ARB:
  - Go to CLEAR next cycle and latch clear_color.
  - No client is accepted in that cycle.
  - A plot already registered from the previous cycle still completes.
- In CLEAR:
  - cx/cy start at (0,0).
  - Emit one pixel per cycle in raster order: cx increments to SCREEN_W-1, then wraps to 0 and cy increments.
  - After (SCREEN_W-1, SCREEN_H-1) is emitted, return to ARB.
  - A full clear is 19200 plots.
  - req_ready=0 throughout CLEAR.
  - clear_start during CLEAR is ignored. The colour is not re-latched.
- Out-of-range client pixels (x ≥ SCREEN_W or y ≥ SCREEN_H) are accepted (ready honoured, pointer advances) but produce plot=0.
- req_ready may depend combinationally on req_valid. Clients must not derive req_valid from req_ready.

## Timing
- Reset values: x=0, y=0, color=0, plot=0, grant_id=0, clear_busy=0, rr_ptr=0, state=ARB.
- Client latency:
  - Acceptance in cycle N gives registered x/y/color/plot=1 in cycle N+1.
  - Sustained throughput is 1 pixel/cycle across all clients.
- Clear timing:
  - clear_start in cycle N gives clear_busy=1 and the plot of (0,0) in cycle N+1.
  - The last plot (159,119) occurs in cycle N+19200.
  - clear_busy falls in cycle N+19201, and clients may be accepted in that same cycle.
- With no acceptance and no clear, plot=0 the next cycle. x/y/color hold their last value.
- Reset asserted mid-clear or mid-plot:
  - Next cycle all outputs take their reset values.
  - The clear is abandoned and is not resumed.
- Simultaneous valid from all clients: grants rotate strictly, 0,1,…,NUM_REQ-1,0.

## Structure
- Shared package plot_pkg holds:
  - SCREEN_W/SCREEN_H constants
  - COLOR_W=3, COORD_W=8
  - the state enum {ARB, CLEAR}

  The VGA top level and the drawing datapaths reuse these.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ; inputs req, ptr, enable; outputs one-hot grant plus index.
  - Purely combinational.
  - The pointer register lives in the parent.
- The parent holds the state register, the clear counters cx/cy, the latched colour, and the output registers.

## Test plan
- Reset: hold reset for 3 cycles with req_valid=2'b11 -> all outputs 0, req_ready=0 during reset, first grant after release goes to client 0.
- Round-robin: both clients hold valid with distinct coords (10,20,c=1) and (30,40,c=2) for 6 cycles -> plots alternate client0/client1 each cycle, 1-cycle latency, grant_id toggles.
- Clear: pulse clear_start with clear_color=3'b101 while client 0 is valid -> client 0 not accepted, 19200 consecutive plots of colour 5 in raster order, last at (159,119), client 0 accepted in the cycle clear_busy falls.
- Out-of-range: client 1 sends (160,5) then (5,120) -> both accepted, plot=0 both cycles, rr_ptr advances.
- Clear retrigger and abort: clear_start again at plot 100 with a new colour -> ignored, colour unchanged; a separate run asserts reset at plot 5000 -> outputs 0 next cycle, state ARB, no further clear plots.
